// File: rtl/fp_pkg.sv
// Shared widths, constants and pipeline stage records for the single-precision subtractor.
package fp_pkg;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int EXP_MAX = 255;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  // hidden bit + mantissa + two guard bits + sticky
  localparam int SIG_W = MAN_W + 4;

  typedef struct packed {
    logic             special;
    logic [31:0]      special_val;
    logic             sign;
    logic             sub;
    logic [EXP_W-1:0] exp;
    logic [SIG_W-1:0] sig_l;
    logic [SIG_W-1:0] sig_s;
  } s1_t;

  typedef struct packed {
    logic             special;
    logic [31:0]      special_val;
    logic             sign;
    logic             zero;
    logic [EXP_W:0]   exp;
    logic [SIG_W-1:0] sig;
  } s2_t;

  function automatic logic [EXP_W-1:0] eff_exp(input logic [EXP_W-1:0] e);
    eff_exp = (e == 8'd0) ? 8'd1 : e;
  endfunction
endpackage

// File: rtl/fp_lzc.sv
// Leading-one detector over the 28-bit adder result; an all-zero input reports position 0.
module fp_lzc
  import fp_pkg::*;
(
  input  logic [SIG_W:0] x,
  output logic [4:0]     pos
);

  // Scan upward so the highest set bit is the last one kept.
  always_comb begin
    pos = 5'd0;
    for (int i = 0; i <= SIG_W; i++) begin
      pos = x[i] ? 5'(i) : pos;
    end
  end

endmodule

// File: rtl/fp_sub_pipe.sv
// Three-stage IEEE-754 single-precision subtractor d = a - b with round-to-nearest-even.
module fp_sub_pipe
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] d
);

  logic             adv;
  s1_t              s1_next, s1;
  s2_t              s2_next, s2;
  logic             v1, v2;
  logic [EXP_W-1:0] e_l, e_s, diff, max_sh;
  logic [23:0]      m_l, m_s;
  logic [51:0]      align;
  logic [SIG_W:0]   sum;
  logic [4:0]       lead, lsh;
  logic [24:0]      rnd;
  logic             inc;
  logic [EXP_W:0]   exp_r;
  logic [MAN_W-1:0] man;
  logic [31:0]      d_next;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // S1: special cases, swap so the larger magnitude is first, align the smaller one.
  always_comb begin
    s1_next = '0;
    if (a[30:0] >= b[30:0]) begin
      e_l = eff_exp(a[30:23]);
      e_s = eff_exp(b[30:23]);
      m_l = {(a[30:23] != 8'd0), a[22:0]};
      m_s = {(b[30:23] != 8'd0), b[22:0]};
      s1_next.sign = a[31];
    end else begin
      e_l = eff_exp(b[30:23]);
      e_s = eff_exp(a[30:23]);
      m_l = {(b[30:23] != 8'd0), b[22:0]};
      m_s = {(a[30:23] != 8'd0), a[22:0]};
      s1_next.sign = ~b[31];
    end
    diff  = e_l - e_s;
    align = {m_s, 28'd0} >> diff;
    s1_next.sub   = (a[31] == b[31]);
    s1_next.exp   = e_l;
    s1_next.sig_l = {m_l, 3'b000};
    if (diff > 8'd26) begin
      s1_next.sig_s = {26'd0, |m_s};
    end else begin
      s1_next.sig_s = {align[51:26], |align[25:0]};
    end
    if (a[30:23] == 8'(EXP_MAX) || b[30:23] == 8'(EXP_MAX)) begin
      s1_next.special     = 1'b1;
      s1_next.special_val = QNAN;
    end else if (b[30:0] == 31'd0) begin
      s1_next.special     = 1'b1;
      s1_next.special_val = a;
    end else if (a[30:0] == 31'd0) begin
      s1_next.special     = 1'b1;
      s1_next.special_val = {~b[31], b[30:0]};
    end else begin
      s1_next.special     = 1'b0;
      s1_next.special_val = 32'd0;
    end
  end

  // S1 register: captures the aligned operand pair whenever the pipe advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      s1 <= '0;
    end else if (adv) begin
      v1 <= in_valid;
      s1 <= s1_next;
    end else begin
      v1 <= v1;
      s1 <= s1;
    end
  end

  assign sum = s1.sub ? ({1'b0, s1.sig_l} - {1'b0, s1.sig_s})
                      : ({1'b0, s1.sig_l} + {1'b0, s1.sig_s});

  fp_lzc u_lzc (
    .x  (sum),
    .pos(lead)
  );

  // S2: normalize so the leading one sits at bit 26, stopping at exponent 1 for denormals.
  always_comb begin
    s2_next             = '0;
    s2_next.special     = s1.special;
    s2_next.special_val = s1.special_val;
    s2_next.sign        = s1.sign;
    s2_next.zero        = (sum == 28'd0);
    lsh    = 5'd26 - lead;
    max_sh = s1.exp - 8'd1;
    if (lead == 5'd27) begin
      s2_next.sig = {sum[27:2], sum[1] | sum[0]};
      s2_next.exp = {1'b0, s1.exp} + 9'd1;
    end else if ({3'b000, lsh} <= max_sh) begin
      s2_next.sig = sum[26:0] << lsh;
      s2_next.exp = {1'b0, s1.exp} - {4'd0, lsh};
    end else begin
      s2_next.sig = sum[26:0] << max_sh;
      s2_next.exp = 9'd0;
    end
  end

  // S2 register: holds the normalized significand and exponent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2 <= 1'b0;
      s2 <= '0;
    end else if (adv) begin
      v2 <= v1;
      s2 <= s2_next;
    end else begin
      v2 <= v2;
      s2 <= s2;
    end
  end

  // S3: round to nearest even, renormalize on carry-out, detect overflow, pack.
  always_comb begin
    inc    = s2.sig[2] & (s2.sig[3] | s2.sig[1] | s2.sig[0]);
    rnd    = {1'b0, s2.sig[26:3]} + {24'd0, inc};
    exp_r  = s2.exp;
    man    = 23'd0;
    d_next = 32'd0;
    if (s2.special) begin
      d_next = s2.special_val;
    end else if (s2.zero) begin
      d_next = 32'd0;
    end else begin
      if (rnd[24]) begin
        exp_r = s2.exp + 9'd1;
        man   = rnd[23:1];
      end else if (s2.exp == 9'd0 && rnd[23]) begin
        exp_r = 9'd1;
        man   = rnd[22:0];
      end else begin
        exp_r = s2.exp;
        man   = rnd[22:0];
      end
      if (exp_r >= 9'(EXP_MAX)) begin
        d_next = {s2.sign, 8'hFF, 23'd0};
      end else begin
        d_next = {s2.sign, exp_r[7:0], man};
      end
    end
  end

  // Output register: result and its valid flag, frozen while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      d         <= 32'd0;
    end else if (adv) begin
      out_valid <= v2;
      d         <= d_next;
    end else begin
      out_valid <= out_valid;
      d         <= d;
    end
  end

endmodule
